// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin share of one AXI read AR/R channel pair between the I and D cache read paths.
// One burst in flight at a time; R beats are steered to whichever side owns the current burst.
module axi_rd_arbiter #(
    parameter logic [3:0] ID_I = 4'd0,
    parameter logic [3:0] ID_D = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [7:0]  i_len,
    input  logic [2:0]  i_size,
    output logic        i_addr_ok,
    output logic        i_rvalid,
    output logic        i_rlast,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [7:0]  d_len,
    input  logic [2:0]  d_size,
    output logic        d_addr_ok,
    output logic        d_rvalid,
    output logic        d_rlast,
    output logic [31:0] d_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_err
);
    typedef enum logic [1:0] {IDLE, AR, R} state_t;
    state_t      state_q;
    logic        gnt_q, last_q, err_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q, cnt_q;
    logic [2:0]  size_q;
    logic        gnt_d;
    logic        bad_beat;
    // gnt: 0 = instruction side, 1 = data side; a tie goes opposite the previous grant
    assign gnt_d    = (i_req & d_req) ? ~last_q : d_req;
    assign bad_beat = (rlast != (cnt_q == len_q)) | (rresp != 2'b00) | (rid != arid);
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_req | d_req) begin
                    state_q <= AR;
                    gnt_q   <= gnt_d;
                    last_q  <= gnt_d;
                    addr_q  <= gnt_d ? d_addr : i_addr;
                    len_q   <= gnt_d ? d_len : i_len;
                    size_q  <= gnt_d ? d_size : i_size;
                    cnt_q   <= '0;
                end
                AR: if (arready) state_q <= R;
                R: if (rvalid) begin
                    cnt_q <= cnt_q + 8'd1;
                    if (bad_beat) err_q <= 1'b1;
                    if (rlast) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign arvalid   = state_q == AR;
    assign rready    = state_q == R;
    assign arid      = gnt_q ? ID_D : ID_I;
    assign araddr    = addr_q;
    assign arlen     = len_q;
    assign arsize    = size_q;
    assign arburst   = 2'b01;
    assign i_addr_ok = arvalid & arready & ~gnt_q;
    assign d_addr_ok = arvalid & arready & gnt_q;
    assign i_rvalid  = rready & rvalid & ~gnt_q;
    assign d_rvalid  = rready & rvalid & gnt_q;
    assign i_rlast   = i_rvalid & rlast;
    assign d_rlast   = d_rvalid & rlast;
    assign i_rdata   = rdata;
    assign d_rdata   = rdata;
    assign rd_err    = err_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed bench for axi_rd_arbiter; inputs change on the falling edge,
// outputs are sampled 1 time unit later.
module tb_axi_rd_arbiter;
    logic        aclk = 1'b0, aresetn = 1'b0;
    logic        i_req = 0, d_req = 0, arready = 0, rlast = 0, rvalid = 0;
    logic [31:0] i_addr = 0, d_addr = 0, rdata = 0;
    logic [7:0]  i_len = 0, d_len = 0;
    logic [2:0]  i_size = 0, d_size = 0;
    logic [3:0]  rid = 0;
    logic [1:0]  rresp = 0;
    logic        i_addr_ok, i_rvalid, i_rlast, d_addr_ok, d_rvalid, d_rlast, arvalid, rready, rd_err;
    logic [31:0] i_rdata, d_rdata, araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    int n_chk = 0, n_fail = 0;

    axi_rd_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_size(i_size),
        .i_addr_ok(i_addr_ok), .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_size(d_size),
        .d_addr_ok(d_addr_ok), .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rdata(d_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .rd_err(rd_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic last, input logic [1:0] resp);
        @(negedge aclk);
        rvalid = 1; rid = id; rdata = data; rlast = last; rresp = resp;
        #1;
    endtask

    task automatic beats_done();
        @(negedge aclk);
        rvalid = 0; rlast = 0; rresp = 0;
        #1;
    endtask

    // Single-beat burst for one side, entered and left on a falling edge in IDLE with the request already up.
    task automatic burst1(input logic side);
        chk1("idle_gap_arvalid", arvalid, 1'b0);
        @(negedge aclk);
        #1;
        chk1("b1_arvalid", arvalid, 1'b1);
        chkw("b1_arid", 32'(arid), side ? 32'd1 : 32'd0);
        chkw("b1_araddr", araddr, side ? d_addr : i_addr);
        arready = 1;
        #1;
        chk1("b1_i_addr_ok", i_addr_ok, ~side);
        chk1("b1_d_addr_ok", d_addr_ok, side);
        @(negedge aclk);
        arready = 0;
        rvalid = 1; rid = side ? 4'd1 : 4'd0; rdata = 32'hA0 + 32'(side); rlast = 1;
        #1;
        chk1("b1_i_rvalid", i_rvalid, ~side);
        chk1("b1_d_rvalid", d_rvalid, side);
        chkw("b1_rdata", side ? d_rdata : i_rdata, 32'hA0 + 32'(side));
        chk1("b1_rlast", side ? d_rlast : i_rlast, 1'b1);
        beats_done();
    endtask

    initial begin
        // reset values
        repeat (2) @(negedge aclk);
        #1;
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_rd_err", rd_err, 1'b0);
        chk1("rst_addr_ok", i_addr_ok | d_addr_ok, 1'b0);
        aresetn = 1;
        @(negedge aclk);
        // tie from reset goes to DATA, then INST; continued contention keeps alternating
        i_req = 1; d_req = 1; i_len = 0; d_len = 0; i_size = 2; d_size = 2;
        i_addr = 32'h1C00_0100; d_addr = 32'h8000_0200;
        burst1(1'b1);
        burst1(1'b0);
        for (int k = 0; k < 4; k++) burst1(k[0] ? 1'b0 : 1'b1);
        i_req = 0; d_req = 0;
        // solo instruction 8-beat line with delayed arready
        @(negedge aclk);
        i_req = 1; i_addr = 32'h1C00_0000; i_len = 7; i_size = 2;
        #1;
        chk1("solo_idle", arvalid, 1'b0);
        @(negedge aclk);
        #1;
        chk1("solo_arvalid", arvalid, 1'b1);
        chkw("solo_arid", 32'(arid), 32'd0);
        chkw("solo_araddr", araddr, 32'h1C00_0000);
        chkw("solo_arlen", 32'(arlen), 32'd7);
        chkw("solo_arsize", 32'(arsize), 32'd2);
        chkw("solo_arburst", 32'(arburst), 32'd1);
        chk1("solo_no_ok_yet", i_addr_ok, 1'b0);
        @(negedge aclk);
        #1;
        chk1("solo_ar_hold", arvalid, 1'b1);
        @(negedge aclk);
        arready = 1;
        #1;
        chk1("solo_i_addr_ok", i_addr_ok, 1'b1);
        chk1("solo_d_addr_ok", d_addr_ok, 1'b0);
        i_req = 0;
        @(negedge aclk);
        arready = 0;
        #1;
        chk1("solo_rready", rready, 1'b1);
        chk1("solo_ok_once", i_addr_ok, 1'b0);
        for (int k = 0; k < 8; k++) begin
            beat(4'd0, 32'h100 + 32'(k), k == 7, 2'b00);
            chk1("solo_i_rvalid", i_rvalid, 1'b1);
            chkw("solo_i_rdata", i_rdata, 32'h100 + 32'(k));
            chk1("solo_i_rlast", i_rlast, k == 7);
            chk1("solo_d_rvalid", d_rvalid, 1'b0);
        end
        beats_done();
        chk1("solo_back_idle", rready, 1'b0);
        chk1("solo_rd_err", rd_err, 1'b0);
        // single-beat data burst
        d_req = 1; d_addr = 32'h8000_0040; d_len = 0;
        @(negedge aclk);
        #1;
        chkw("single_arlen", 32'(arlen), 32'd0);
        chkw("single_arid", 32'(arid), 32'd1);
        arready = 1;
        #1;
        chk1("single_d_addr_ok", d_addr_ok, 1'b1);
        d_req = 0;
        @(negedge aclk);
        arready = 0;
        #1;
        chk1("single_ok_once", d_addr_ok, 1'b0);
        beat(4'd1, 32'h55, 1'b1, 2'b00);
        chk1("single_d_rvalid", d_rvalid, 1'b1);
        chk1("single_d_rlast", d_rlast, 1'b1);
        beats_done();
        chk1("single_rd_err", rd_err, 1'b0);
        // early rlast: len=3 but rlast on beat 2
        d_req = 1; d_len = 3;
        @(negedge aclk);
        arready = 1;
        d_req = 0;
        @(negedge aclk);
        arready = 0;
        beat(4'd1, 32'h1, 1'b0, 2'b00);
        beat(4'd1, 32'h2, 1'b1, 2'b00);
        beats_done();
        chk1("early_rd_err", rd_err, 1'b1);
        chk1("early_idle_rready", rready, 1'b0);
        chk1("early_idle_arvalid", arvalid, 1'b0);
        // reset mid-burst
        i_req = 1; i_len = 7;
        @(negedge aclk);
        arready = 1;
        i_req = 0;
        @(negedge aclk);
        arready = 0;
        beat(4'd0, 32'h77, 1'b0, 2'b00);
        chk1("mid_i_rvalid", i_rvalid, 1'b1);
        @(negedge aclk);
        aresetn = 0;
        #1;
        chk1("mid_rst_arvalid", arvalid, 1'b0);
        chk1("mid_rst_rready", rready, 1'b0);
        chk1("mid_rst_rd_err", rd_err, 1'b0);
        chk1("mid_rst_i_rvalid", i_rvalid, 1'b0);
        @(negedge aclk);
        aresetn = 1;
        #1;
        chk1("post_rst_i_rvalid", i_rvalid, 1'b0);
        @(negedge aclk);
        #1;
        chk1("post_rst_i_rvalid2", i_rvalid, 1'b0);
        chk1("post_rst_rready", rready, 1'b0);
        rvalid = 0;
        // error response, then sticky across a clean burst
        i_req = 1; i_len = 1;
        @(negedge aclk);
        arready = 1;
        i_req = 0;
        @(negedge aclk);
        arready = 0;
        beat(4'd0, 32'h9, 1'b0, 2'b10);
        beat(4'd0, 32'hA, 1'b1, 2'b00);
        beats_done();
        chk1("rresp_rd_err", rd_err, 1'b1);
        d_req = 1; d_len = 0;
        burst1(1'b1);
        d_req = 0;
        @(negedge aclk);
        #1;
        chk1("sticky_rd_err", rd_err, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
